// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that lets two requesters share one
// combinational ALU. One operation is in flight at a time: it is accepted in
// IDLE, driven into the ALU for one EXEC cycle, and then held in RESP until
// the owning requester takes the response.
module alu_arbiter #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_data0,
    input  logic [2*DATA_W-1:0] req_data1,
    input  logic [2*OP_W-1:0]   req_instruction,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic                rsp_carry,
    output logic                rsp_zero,
    output logic [DATA_W-1:0]   alu_data0,
    output logic [DATA_W-1:0]   alu_data1,
    output logic [OP_W-1:0]     alu_instruction,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_carry,
    input  logic                alu_zero,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                last_grant_r;
    logic                owner_r;
    logic                grant_s;
    logic                accept_s;
    logic [DATA_W-1:0]   op_data0_r;
    logic [DATA_W-1:0]   op_data1_r;
    logic [OP_W-1:0]     op_instruction_r;
    logic [DATA_W-1:0]   rsp_result_r;
    logic                rsp_carry_r;
    logic                rsp_zero_r;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_s = 1'b0;
        if (req_valid == 2'b11) begin
            grant_s = ~last_grant_r;
        end else if (req_valid[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // FSM next state and handshake outputs; everything is quiet while rst is high.
    always_comb begin
        state_next_s = state_r;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;
        busy         = 1'b0;
        accept_s     = 1'b0;
        if (rst) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        req_ready[grant_s] = 1'b1;
                        accept_s           = 1'b1;
                        state_next_s       = EXEC;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                EXEC: begin
                    busy         = 1'b1;
                    state_next_s = RESP;
                end
                RESP: begin
                    busy               = 1'b1;
                    rsp_valid[owner_r] = 1'b1;
                    if (rsp_ready[owner_r]) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = RESP;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State register and round-robin history; requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                last_grant_r <= grant_s;
            end
        end
    end

    // Operation registers: loaded only on an accepted request, they feed the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_data0_r       <= {DATA_W{1'b0}};
            op_data1_r       <= {DATA_W{1'b0}};
            op_instruction_r <= {OP_W{1'b0}};
            owner_r          <= 1'b0;
        end else if (accept_s) begin
            op_data0_r       <= grant_s ? req_data0[2*DATA_W-1:DATA_W] : req_data0[DATA_W-1:0];
            op_data1_r       <= grant_s ? req_data1[2*DATA_W-1:DATA_W] : req_data1[DATA_W-1:0];
            op_instruction_r <= grant_s ? req_instruction[2*OP_W-1:OP_W] : req_instruction[OP_W-1:0];
            owner_r          <= grant_s;
        end
    end

    // Response registers: capture the ALU outputs at the end of the EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result_r <= {DATA_W{1'b0}};
            rsp_carry_r  <= 1'b0;
            rsp_zero_r   <= 1'b0;
        end else if (state_r == EXEC) begin
            rsp_result_r <= alu_result;
            rsp_carry_r  <= alu_carry;
            rsp_zero_r   <= alu_zero;
        end
    end

    assign alu_data0       = op_data0_r;
    assign alu_data1       = op_data1_r;
    assign alu_instruction = op_instruction_r;
    assign rsp_result      = rsp_result_r;
    assign rsp_carry       = rsp_carry_r;
    assign rsp_zero        = rsp_zero_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench. A transaction-level model (free/busy,
// owner, age since accept, round-robin history) predicts every handshake
// output each cycle; expected responses are queued at accept and popped by
// the monitor when the response is taken.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_data0;
    logic [15:0] req_data1;
    logic [7:0]  req_instruction;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [7:0]  rsp_result;
    logic        rsp_carry;
    logic        rsp_zero;
    logic [7:0]  alu_data0;
    logic [7:0]  alu_data1;
    logic [3:0]  alu_instruction;
    logic [7:0]  alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(8), .OP_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data0(req_data0), .req_data1(req_data1),
        .req_instruction(req_instruction),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .alu_data0(alu_data0), .alu_data1(alu_data1),
        .alu_instruction(alu_instruction),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .busy(busy)
    );

    // Reference ALU: returns {carry, result}. Code 0 is add.
    function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a | b};
            4'd4:    return {1'b0, a ^ b};
            4'd5:    return {a, 1'b0};
            4'd6:    return {a[0], 1'b0, a[7:1]};
            4'd7:    return {1'b0, b};
            4'd8:    return {1'b0, a} + 9'd1;
            4'd9:    return {1'b0, a} - 9'd1;
            4'd10:   return {1'b0, ~a};
            4'd11:   return {1'b0, a} + {1'b0, b} + 9'd1;
            default: return {1'b0, a};
        endcase
    endfunction

    // Stand-in for the shared ALU instance.
    always_comb begin
        {alu_carry, alu_result} = alu_ref(alu_instruction, alu_data0, alu_data1);
        alu_zero = (alu_result == 8'h00);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    typedef struct {
        bit         owner;
        logic [7:0] res;
        logic       carry;
        logic       zero;
    } exp_t;

    exp_t       exp_q[$];
    bit         grants[$];
    bit         m_free  = 1'b1;
    bit         m_owner = 1'b0;
    bit         m_last  = 1'b1;
    int         m_age   = 0;
    logic [7:0] m_d0 = 8'h00, m_d1 = 8'h00;
    logic [3:0] m_op = 4'h0;

    // Monitor + model: compare this cycle's outputs, then advance the model to the next edge.
    always @(negedge clk) begin
        logic [1:0] exp_rr;
        logic [1:0] exp_rv;
        bit         win;
        bit         exp_busy;
        logic [8:0] r;
        exp_t       e;
        win    = 1'b0;
        exp_rr = 2'b00;
        if (!rst && m_free && req_valid != 2'b00) begin
            win    = (req_valid == 2'b11) ? ~m_last : req_valid[1];
            exp_rr = win ? 2'b10 : 2'b01;
        end
        exp_rv   = (!rst && !m_free && m_age >= 1) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        exp_busy = !rst && !m_free;
        chk("req_ready", req_ready, exp_rr);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("busy", busy, exp_busy);
        chk("alu_data0", alu_data0, m_d0);
        chk("alu_data1", alu_data1, m_d1);
        chk("alu_instruction", alu_instruction, m_op);
        if (exp_rv != 2'b00) begin
            if (exp_q.size() == 0) begin
                timeout("rsp_no_expected");
            end else begin
                chk("rsp_result", rsp_result, exp_q[0].res);
                chk("rsp_carry", rsp_carry, exp_q[0].carry);
                chk("rsp_zero", rsp_zero, exp_q[0].zero);
            end
        end
        if (rst) begin
            m_free = 1'b1; m_last = 1'b1; m_age = 0;
            m_d0 = 8'h00; m_d1 = 8'h00; m_op = 4'h0;
            exp_q.delete();
        end else if (m_free && exp_rr != 2'b00) begin
            m_free  = 1'b0;
            m_owner = win;
            m_last  = win;
            m_age   = 0;
            m_d0    = req_data0[win*8 +: 8];
            m_d1    = req_data1[win*8 +: 8];
            m_op    = req_instruction[win*4 +: 4];
            r       = alu_ref(m_op, m_d0, m_d1);
            e.owner = win; e.res = r[7:0]; e.carry = r[8]; e.zero = (r[7:0] == 8'h00);
            exp_q.push_back(e);
            grants.push_back(win);
        end else if (!m_free) begin
            if (m_age >= 1 && rsp_ready[m_owner]) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_free = 1'b1;
            end else begin
                m_age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]           = 1'b1;
        req_instruction[i*4 +: 4] = op;
        req_data0[i*8 +: 8]    = a;
        req_data1[i*8 +: 8]    = b;
    endtask

    task automatic wait_accept(input int i);
        bit got = 1'b0;
        int n   = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            got = req_valid[i] & req_ready[i];
            tick();
            n++;
        end
        if (!got) timeout("wait_accept");
    endtask

    task automatic issue(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        set_req(i, op, a, b);
        wait_accept(i);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_free();
        int n = 0;
        while (!m_free && n < 50) begin
            tick();
            n++;
        end
        if (!m_free) timeout("wait_free");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [1:0] hs;
        int       n;
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
        req_data0 = 16'h0000; req_data1 = 16'h0000; req_instruction = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single request: 0x0F + 0x01 from requester 0.
        issue(0, 4'd0, 8'h0F, 8'h01);
        wait_free();
        tick();

        // Tie-break and round-robin from reset release.
        rst = 1'b1;
        set_req(0, 4'd0, 8'($urandom), 8'($urandom));
        set_req(1, 4'd1, 8'($urandom), 8'($urandom));
        repeat (2) tick();
        grants.delete();
        rst = 1'b0;
        n = 0;
        while (grants.size() < 4 && n < 40) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            tick();
            for (int i = 0; i < 2; i++)
                if (hs[i]) set_req(i, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
            n++;
        end
        req_valid = 2'b00;
        if (grants.size() < 4) timeout("rr_grants");
        else for (int k = 0; k < 4; k++) chk("rr_order", grants[k], k % 2);
        wait_free();

        // Flags: 0xFF + 0x01 from requester 1.
        issue(1, 4'd0, 8'hFF, 8'h01);
        wait_free();

        // Response backpressure with requester 1 waiting.
        rsp_ready = 2'b10;
        issue(0, 4'd4, 8'hA5, 8'h3C);
        set_req(1, 4'd2, 8'hF0, 8'h3F);
        repeat (6) tick();
        rsp_ready = 2'b11;
        wait_accept(1);
        req_valid[1] = 1'b0;
        wait_free();

        // Reset while the operation is in EXEC.
        issue(0, 4'd0, 8'h12, 8'h34);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        set_req(0, 4'd3, 8'h81, 8'h18);
        set_req(1, 4'd5, 8'hC3, 8'h00);
        wait_accept(0);
        req_valid[0] = 1'b0;
        if (grants.size() > 0) chk("rst_tie_grant", grants[grants.size()-1], 1'b0);
        wait_accept(1);
        req_valid[1] = 1'b0;
        wait_free();

        // Opcode sweep from requester 0.
        for (int op = 0; op < 16; op++) begin
            issue(0, 4'(op), 8'($urandom), 8'($urandom));
            wait_free();
        end

        // Randomized traffic with withdrawals and response backpressure.
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            tick();
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && !hs[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'b0;
                    if ($urandom_range(0, 1) == 1)
                        set_req(i, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
                end
            end
            rsp_ready[0] = ($urandom_range(0, 2) != 0);
            rsp_ready[1] = ($urandom_range(0, 2) != 0);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        wait_free();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
